// File: rtl/cpu_pkg.sv
// Shared opcode map, machine-cycle state encoding and opcode class helper
// for the small CPU's controller.
package cpu_pkg;

    localparam int OPC_W = 3;

    typedef enum logic [OPC_W-1:0] {
        OP_HLT = 3'b000,
        OP_SKZ = 3'b001,
        OP_ADD = 3'b010,
        OP_AND = 3'b011,
        OP_XOR = 3'b100,
        OP_LDA = 3'b101,
        OP_STO = 3'b110,
        OP_JMP = 3'b111
    } opcode_e;

    typedef enum logic [3:0] {
        S0     = 4'd0,
        S1     = 4'd1,
        S2     = 4'd2,
        S3     = 4'd3,
        S4     = 4'd4,
        S5     = 4'd5,
        S6     = 4'd6,
        S7     = 4'd7,
        HALTED = 4'd8
    } state_e;

    // Instructions that read an operand from memory into the accumulator.
    function automatic logic is_alu_op(input logic [OPC_W-1:0] opcode);
        return (opcode == OP_ADD) || (opcode == OP_AND) ||
               (opcode == OP_XOR) || (opcode == OP_LDA);
    endfunction

endpackage

// File: rtl/cpu_controller.sv
// Eight-cycle machine-cycle sequencer: fetches the two IR bytes, then decodes
// the opcode into per-cycle PC, accumulator, memory and bus strobes.
module cpu_controller
    import cpu_pkg::*;
(
    input  logic             CLK,
    input  logic             RST,
    input  logic             ENA,
    input  logic [OPC_W-1:0] OPCODE,
    input  logic             ZERO,
    output logic             LOAD_IR,
    output logic             INC_PC,
    output logic             LOAD_PC,
    output logic             LOAD_ACC,
    output logic             RD,
    output logic             WR,
    output logic             DATACTL_ENA,
    output logic             HALT
);

    state_e state_q;
    state_e state_d;
    logic   alu_op;
    logic   skz_taken;

    assign alu_op    = is_alu_op(OPCODE);
    assign skz_taken = (OPCODE == OP_SKZ) && ZERO;

    always_comb begin
        state_d = state_q;
        if (state_q == HALTED) begin
            state_d = HALTED;
        end else if (!ENA) begin
            state_d = S0;
        end else begin
            case (state_q)
                S3:                     state_d = (OPCODE == OP_HLT) ? HALTED : S4;
                S7:                     state_d = S0;
                S0, S1, S2, S4, S5, S6: state_d = state_e'(state_q + 4'd1);
                default:                state_d = S0;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= S0;
        end else begin
            state_q <= state_d;
        end
    end

    // Outputs follow the current state combinationally; ENA gates everything
    // except the HALTED indication, and reset forces all of them low.
    always_comb begin
        LOAD_IR     = 1'b0;
        INC_PC      = 1'b0;
        LOAD_PC     = 1'b0;
        LOAD_ACC    = 1'b0;
        RD          = 1'b0;
        WR          = 1'b0;
        DATACTL_ENA = 1'b0;
        HALT        = 1'b0;
        if (RST) begin
            if (state_q == HALTED) begin
                HALT = 1'b1;
            end else if (ENA) begin
                case (state_q)
                    S0: begin
                        RD      = 1'b1;
                        LOAD_IR = 1'b1;
                    end
                    S1: begin
                        RD      = 1'b1;
                        LOAD_IR = 1'b1;
                        INC_PC  = 1'b1;
                    end
                    S3: begin
                        INC_PC = 1'b1;
                        HALT   = (OPCODE == OP_HLT);
                    end
                    S4: begin
                        RD      = alu_op;
                        LOAD_PC = (OPCODE == OP_JMP);
                    end
                    S5: begin
                        RD          = alu_op;
                        LOAD_ACC    = alu_op;
                        LOAD_PC     = (OPCODE == OP_JMP);
                        INC_PC      = (OPCODE == OP_JMP) || skz_taken;
                        DATACTL_ENA = (OPCODE == OP_STO);
                    end
                    S6: begin
                        RD          = alu_op;
                        WR          = (OPCODE == OP_STO);
                        DATACTL_ENA = (OPCODE == OP_STO);
                    end
                    S7: begin
                        DATACTL_ENA = (OPCODE == OP_STO);
                        INC_PC      = skz_taken;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cpu_controller.sv
// Bench for cpu_controller: a phase/halted model checked every cycle, plus
// directed instruction sequences with literal per-cycle strobe vectors.
module tb_cpu_controller;

    logic       CLK;
    logic       RST;
    logic       ENA;
    logic [2:0] OPCODE;
    logic       ZERO;
    logic       LOAD_IR, INC_PC, LOAD_PC, LOAD_ACC, RD, WR, DATACTL_ENA, HALT;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    int m_ph     = 0;
    bit m_halted = 1'b0;

    cpu_controller dut (
        .CLK        (CLK),
        .RST        (RST),
        .ENA        (ENA),
        .OPCODE     (OPCODE),
        .ZERO       (ZERO),
        .LOAD_IR    (LOAD_IR),
        .INC_PC     (INC_PC),
        .LOAD_PC    (LOAD_PC),
        .LOAD_ACC   (LOAD_ACC),
        .RD         (RD),
        .WR         (WR),
        .DATACTL_ENA(DATACTL_ENA),
        .HALT       (HALT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Vector order: {LOAD_IR, INC_PC, LOAD_PC, LOAD_ACC, RD, WR, DATACTL_ENA, HALT}
    function automatic logic [7:0] act_vec();
        return {LOAD_IR, INC_PC, LOAD_PC, LOAD_ACC, RD, WR, DATACTL_ENA, HALT};
    endfunction

    // Instruction-phase model: phase counts ENA cycles since the instruction began.
    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            m_ph     <= 0;
            m_halted <= 1'b0;
        end else if (!m_halted) begin
            if (!ENA)                              m_ph <= 0;
            else if (m_ph == 3 && OPCODE == 3'd0)  m_halted <= 1'b1;
            else                                   m_ph <= (m_ph + 1) % 8;
        end
    end

    function automatic logic [7:0] model_out(int ph, bit halted, logic ena, logic rst,
                                             logic [2:0] op, logic z);
        bit alu, ld_ir, inc, ldpc, ldacc, rd, wr, dat, hlt;
        if (!rst)   return 8'h00;
        if (halted) return 8'h01;
        if (!ena)   return 8'h00;
        alu   = (op >= 3'd2) && (op <= 3'd5);
        ld_ir = (ph < 2);
        rd    = (ph < 2) || (alu && ph >= 4 && ph <= 6);
        inc   = (ph == 1) || (ph == 3) || (op == 3'd1 && z && (ph == 5 || ph == 7))
                || (op == 3'd7 && ph == 5);
        ldpc  = (op == 3'd7) && (ph == 4 || ph == 5);
        ldacc = alu && (ph == 5);
        wr    = (op == 3'd6) && (ph == 6);
        dat   = (op == 3'd6) && (ph >= 5);
        hlt   = (ph == 3) && (op == 3'd0);
        return {ld_ir, inc, ldpc, ldacc, rd, wr, dat, hlt};
    endfunction

    always @(negedge CLK) begin
        logic [7:0] exp_v;
        logic [7:0] got_v;
        cycle++;
        exp_v = model_out(m_ph, m_halted, ENA, RST, OPCODE, ZERO);
        got_v = act_vec();
        checks++;
        if (got_v !== exp_v) begin
            errors++;
            $display("FAIL model cycle %0d phase %0d: got %b expected %b", cycle, m_ph, got_v, exp_v);
        end
        if (RD === 1'b1 && WR === 1'b1) begin
            errors++;
            $display("FAIL rd_wr_exclusive cycle %0d: RD and WR both 1", cycle);
        end
    end

    task automatic lit_check(input string nm, input logic [7:0] exp_v);
        logic [7:0] got_v;
        got_v = act_vec();
        checks++;
        if (got_v !== exp_v) begin
            errors++;
            $display("FAIL %s: got %b expected %b", nm, got_v, exp_v);
        end else begin
            $display("ok   %s: %b", nm, got_v);
        end
    endtask

    // Entered at posedge+1; drives one cycle's inputs, checks mid-cycle, advances.
    task automatic cyc(input logic ena, input logic [2:0] op, input logic z,
                       input logic [7:0] exp_v, input string nm);
        ENA    = ena;
        OPCODE = op;
        ZERO   = z;
        #2;
        lit_check(nm, exp_v);
        @(posedge CLK);
        #1;
    endtask

    task automatic run_instr(input string nm, input logic [2:0] op, input logic z,
                             input logic [63:0] exp_all);
        for (int ph = 0; ph < 8; ph++) begin
            cyc(1'b1, op, z, exp_all[63 - 8*ph -: 8], $sformatf("%s_S%0d", nm, ph));
        end
    endtask

    localparam logic [63:0] ADD_V  = 64'h88C8_0040_0818_0800;
    localparam logic [63:0] STO_V  = 64'h88C8_0040_0002_0602;
    localparam logic [63:0] SKZ1_V = 64'h88C8_0040_0040_0040;
    localparam logic [63:0] SKZ0_V = 64'h88C8_0040_0000_0000;
    localparam logic [63:0] JMP_V  = 64'h88C8_0040_2060_0000;

    initial begin
        logic [63:0] add_v;
        add_v  = ADD_V;
        RST    = 1'b0;
        ENA    = 1'b0;
        OPCODE = 3'd0;
        ZERO   = 1'b0;
        @(posedge CLK);
        #1;
        ENA = 1'b1;
        #2;
        lit_check("reset_outputs_low", 8'h00);
        @(posedge CLK);
        #1;
        RST = 1'b1;

        run_instr("ADD", 3'd2, 1'b0, ADD_V);
        run_instr("STO", 3'd6, 1'b0, STO_V);
        run_instr("SKZ_Z1", 3'd1, 1'b1, SKZ1_V);
        run_instr("SKZ_Z0", 3'd1, 1'b0, SKZ0_V);
        run_instr("JMP", 3'd7, 1'b0, JMP_V);

        // Abort ADD at S5, then restart from S0.
        for (int ph = 0; ph < 5; ph++)
            cyc(1'b1, 3'd2, 1'b0, add_v[63 - 8*ph -: 8], $sformatf("ABORT_ADD_S%0d", ph));
        cyc(1'b0, 3'd2, 1'b0, 8'h00, "ABORT_ENA_LOW");
        run_instr("RESTART_ADD", 3'd2, 1'b1, ADD_V);

        // HLT: fetch, S3 halt strobe, then HALTED regardless of ENA/OPCODE.
        cyc(1'b1, 3'd0, 1'b0, 8'h88, "HLT_S0");
        cyc(1'b1, 3'd0, 1'b0, 8'hC8, "HLT_S1");
        cyc(1'b1, 3'd0, 1'b0, 8'h00, "HLT_S2");
        cyc(1'b1, 3'd0, 1'b0, 8'h41, "HLT_S3");
        for (int i = 0; i < 20; i++)
            cyc(i[0], i[2:0], i[1], 8'h01, $sformatf("HALTED_%0d", i));

        // Asynchronous reset clears HALT before the next edge.
        RST = 1'b0;
        #1;
        lit_check("async_reset_clears_halt", 8'h00);
        @(posedge CLK);
        #1;
        RST = 1'b1;
        run_instr("POST_RESET_ADD", 3'd2, 1'b0, ADD_V);

        @(negedge CLK);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
